stage3_event_monitor: RTL and testbench
=======================================

// Module: stage3_event_monitor
// PURPOSE
//  Downstream stage that consumes the ff2 output of stage2. It detects rising edges on ff2 and counts them
//  over fixed-length windows, reporting the count once per window. It also keeps a saturating lifetime total
//  and raises a sticky alarm when a window's count reaches THRESH. Sits at the output of top, after stage2.
// PARAMETERS
//  CNT_W    8   width of the window and total edge counters
//  WIN_LEN  16  window length in clk cycles (>=2)
//  THRESH   4   alarm when window edge count >= THRESH
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous reset, active-high
//  ff2        in   1      monitored bit from stage2
//  en         in   1      1 = monitor windows, 0 = idle
//  clr        in   1      sync clear of alarm, total_cnt and current window
//  win_count  out  CNT_W  edge count of last completed window
//  win_valid  out  1      1-cycle strobe: win_count updated
//  alarm      out  1      sticky threshold flag
//  total_cnt  out  CNT_W  saturating count of all counted edges
//  busy       out  1      1 when state != IDLE
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). Priority rst > clr > en.
//  - Reset: all outputs 0; state=IDLE; ff2_q=0; win_cnt=0; ev_cnt=0.
//  - ff2_q <= ff2 every cycle. rise = ff2 & ~ff2_q, evaluated combinationally in the current cycle.
//  - rise is counted only in cycles where state is RUN or ALARM. A level held high counts once.
//  - FSM states:
//    - IDLE: en=1 -> RUN with win_cnt=0, ev_cnt=0. The transition cycle itself counts no edge.
//    - RUN: win_cnt++ each cycle. ev_cnt += rise, saturating at 2^CNT_W-1.
//    - RUN, en=0: -> IDLE. The partial window is discarded: no win_valid, ev_cnt=0, win_cnt=0.
//    - Window end (RUN or ALARM, win_cnt==WIN_LEN-1):
//      - n = sat(ev_cnt+rise), so an edge in the last cycle is included.
//      - Next cycle: win_count=n and win_valid=1 for exactly 1 cycle.
//      - ev_cnt=0 and win_cnt=0, so the next window starts with no gap.
//      - If n>=THRESH: alarm=1 on the same cycle as win_valid, and state -> ALARM.
//    - ALARM: counting and reporting continue exactly as in RUN. alarm stays 1 regardless of later windows.
//    - ALARM, en=0: -> IDLE, alarm stays 1.
//  - Window period is WIN_LEN cycles; the first strobe comes WIN_LEN cycles after the RUN-entry cycle.
//  - total_cnt += rise in RUN/ALARM, saturating at 2^CNT_W-1. It never wraps and is held in IDLE.
//  - clr=1 (any state):
//    - Next cycle: alarm=0, total_cnt=0, win_cnt=0, ev_cnt=0, win_valid=0.
//    - Next state is RUN if en=1, else IDLE. win_count keeps its last value.
//    - An edge in the clr cycle is not counted.
//    - A window end coinciding with clr is dropped: no strobe, no alarm.
//  - rst mid-window: everything returns to reset values next cycle, and the partial window is lost.
//  - busy = (state != IDLE), registered.
// TESTING
//  1 Reset: hold rst 2 cycles with ff2=1, en=1 -> all outputs 0 and busy=0 during and 1 cycle after reset.
//  2 Below threshold (defaults): en=1, then 3 one-cycle ff2 pulses in window ->
//    win_valid pulses 16 cycles after RUN entry with win_count=3, alarm=0, total_cnt=3.
//  3 Threshold: 4 pulses, the last in the final window cycle -> win_count=4, alarm=1 together with win_valid.
//    Next window has 0 edges -> win_count=0, alarm stays 1.
//  4 Level/saturation: ff2 held 1 for 40 cycles -> 1 edge counted.
//    With CNT_W=3, 10 separate pulses -> total_cnt=7 (no wrap).
//  5 Abort: en drops at win_cnt=10 -> no win_valid, busy=0 next cycle.
//    en=1 again -> fresh 16-cycle window starting from 0.
//  6 Clear: clr while alarm=1 and window end coincides -> next cycle alarm=0, total_cnt=0, no strobe.
//    If en=1, the next window strobe comes 16 cycles later.

Source files
------------

// File: rtl/stage3_event_monitor.sv
// ---------------------------------------------------------------------------
// stage3_event_monitor
//
// Downstream monitor on the ff2 bit coming out of stage2. It finds rising
// edges of ff2 and counts them over back-to-back windows of WIN_LEN cycles.
// At the end of each window it reports the count with a one-cycle strobe.
// It also keeps a saturating lifetime total of counted edges. A sticky alarm
// is raised when any window's count reaches THRESH.
//
// Parameters
//   CNT_W    width of the window count and the lifetime total
//   WIN_LEN  window length in clk cycles (must be >= 2)
//   THRESH   a window count >= THRESH raises the alarm
//
// Ports
//   clk        in   1      system clock; all logic runs on the rising edge
//   rst        in   1      synchronous reset, active-high
//   ff2        in   1      monitored bit from stage2
//   en         in   1      1 = run windows, 0 = idle (a partial window is dropped)
//   clr        in   1      synchronous clear of alarm, total and current window
//   win_count  out  CNT_W  edge count of the last completed window
//   win_valid  out  1      one-cycle strobe; win_count was just updated
//   alarm      out  1      sticky flag for a window that reached THRESH
//   total_cnt  out  CNT_W  saturating count of all counted edges
//   busy       out  1      registered, 1 while the FSM is not IDLE
//
// Priority of the control inputs is rst > clr > en.
// ---------------------------------------------------------------------------
module stage3_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ff2,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] win_count,
  output logic             win_valid,
  output logic             alarm,
  output logic [CNT_W-1:0] total_cnt,
  output logic             busy
);

  // The window position counter only has to reach WIN_LEN-1.
  localparam int WC_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // FSM encoding.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic             ff2_q;
  logic [WC_W-1:0]  win_cnt;
  logic [CNT_W-1:0] ev_cnt;

  logic             rise;
  logic             counting;
  logic             win_end;
  logic [CNT_W-1:0] ev_next;
  logic [CNT_W-1:0] total_next;
  logic             hit;

  // Increment by one bit, but stick at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // Edge detection and window bookkeeping.
  // Edges count only while a window is really advancing: the state is RUN
  // or ALARM and en is still high. The cycle that leaves for IDLE is
  // therefore not counted. A clr cycle is excluded further down by its
  // own branch. win_end marks the last cycle of a window. The edge seen in
  // that cycle is folded into the reported count through ev_next.
  always_comb begin
    rise       = ff2 & ~ff2_q;
    counting   = ((state == RUN) || (state == ALARM)) && en;
    win_end    = counting && (win_cnt == WIN_LAST);
    ev_next    = sat_inc(ev_cnt, rise);
    total_next = sat_inc(total_cnt, rise);
    hit        = (int'(ev_next) >= THRESH);
  end

  // Next-state logic.
  // clr wins over everything except reset. After clr the FSM restarts a
  // fresh window if en is high. The ALARM state is dropped because the
  // alarm flag itself is cleared. A window that ends with a hit moves
  // RUN to ALARM. ALARM keeps counting exactly like RUN.
  always_comb begin
    state_d = state;
    if (clr) begin
      state_d = en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state_d = RUN;
          end
        end
        RUN, ALARM: begin
          if (!en) begin
            state_d = IDLE;
          end else if (win_end && hit) begin
            state_d = ALARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register, plus busy registered from the next state.
  // busy therefore changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
    end
  end

  // Previous-cycle copy of ff2 for the rise detector.
  // It follows ff2 even while idle or clearing. This means a level that is
  // already high when counting starts is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff2_q <= 1'b0;
    end else begin
      ff2_q <= ff2;
    end
  end

  // Window position and in-window edge count.
  // Both counters reset at a window end so that the next window follows
  // with no gap. Outside of counting cycles they are held at zero. This
  // covers idle cycles, RUN entry, an aborted window and a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      ev_cnt  <= '0;
    end else if (clr || !counting || win_end) begin
      win_cnt <= '0;
      ev_cnt  <= '0;
    end else begin
      win_cnt <= win_cnt + WC_W'(1);
      ev_cnt  <= ev_next;
    end
  end

  // Window report and sticky alarm.
  // The strobe is the default-low pulse, set only on the edge that closes
  // a window. A clear on that same cycle suppresses both the report and
  // the alarm. win_count is left alone by clr so the last report stays
  // readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_count <= '0;
      win_valid <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (clr) begin
        alarm <= 1'b0;
      end else if (win_end) begin
        win_count <= ev_next;
        win_valid <= 1'b1;
        if (hit) begin
          alarm <= 1'b1;
        end
      end
    end
  end

  // Lifetime total of counted edges.
  // It saturates instead of wrapping, and it holds its value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_cnt <= '0;
    end else if (clr) begin
      total_cnt <= '0;
    end else if (counting) begin
      total_cnt <= total_next;
    end
  end

endmodule

// File: tb/tb_stage3_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_stage3_event_monitor
//
// Directed bench for stage3_event_monitor. The main instance uses the default
// parameters. A second instance with CNT_W=3 shares every input and is used
// to show saturation. Each scenario task drives its own vectors and checks
// the results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_stage3_event_monitor;

  logic       clk;
  logic       rst;
  logic       ff2;
  logic       en;
  logic       clr;

  logic [7:0] win_count;
  logic       win_valid;
  logic       alarm;
  logic [7:0] total_cnt;
  logic       busy;

  logic [2:0] win_count3;
  logic       win_valid3;
  logic       alarm3;
  logic [2:0] total_cnt3;
  logic       busy3;

  int tests_run;
  int tests_failed;

  stage3_event_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .ff2       (ff2),
    .en        (en),
    .clr       (clr),
    .win_count (win_count),
    .win_valid (win_valid),
    .alarm     (alarm),
    .total_cnt (total_cnt),
    .busy      (busy)
  );

  stage3_event_monitor #(.CNT_W(3), .WIN_LEN(16), .THRESH(4)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .ff2       (ff2),
    .en        (en),
    .clr       (clr),
    .win_count (win_count3),
    .win_valid (win_valid3),
    .alarm     (alarm3),
    .total_cnt (total_cnt3),
    .busy      (busy3)
  );

  // 10-unit clock. Inputs change 1 unit after a rising edge, and outputs
  // are read at that same point, before the inputs for the next edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    ff2 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Reset with ff2 and en held high. Everything reads zero.
  task automatic test_reset();
    rst = 1'b1;
    ff2 = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if ({win_count, win_valid, alarm, total_cnt, busy} !== 19'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", i,
                 {win_count, win_valid, alarm, total_cnt, busy});
      end
      tests_run++;
      if ({win_count3, win_valid3, alarm3, total_cnt3, busy3} !== 9'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs_w3 cycle %0d: got %h expected 0", i,
                 {win_count3, win_valid3, alarm3, total_cnt3, busy3});
      end
    end
    rst = 1'b0;
    #4;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy_after: got %b expected 0", busy);
    end
    step();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_run_entry_busy: got %b expected 1", busy);
    end
    step();
    tests_run++;
    if (total_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_level_not_edge: got %0d expected 0", total_cnt);
    end
    en  = 1'b0;
    ff2 = 1'b0;
  endtask

  // Three pulses in one window stay below the threshold.
  task automatic test_below_threshold();
    int early;
    early = 0;
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 16; c++) begin
      ff2 = (c == 2 || c == 5 || c == 8);
      step();
      if (c < 15 && win_valid) early++;
    end
    ff2 = 1'b0;
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("[TB] FAIL below_early_strobe: got %0d expected 0", early);
    end
    tests_run++;
    if ({win_valid, win_count, alarm, total_cnt} !== {1'b1, 8'd3, 1'b0, 8'd3}) begin
      tests_failed++;
      $display("[TB] FAIL below_report: got v=%b n=%0d a=%b t=%0d expected v=1 n=3 a=0 t=3",
               win_valid, win_count, alarm, total_cnt);
    end
    step();
    tests_run++;
    if (win_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL below_strobe_width: got %b expected 0", win_valid);
    end
  endtask

  // Four pulses, the last in the final cycle. Alarm comes with the strobe.
  task automatic test_threshold();
    int   early;
    logic alarm_pre;
    early     = 0;
    alarm_pre = 1'bx;
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 16; c++) begin
      ff2 = (c == 1 || c == 4 || c == 7 || c == 15);
      step();
      if (c < 15 && win_valid) early++;
      if (c == 14) alarm_pre = alarm;
    end
    tests_run++;
    if (alarm_pre !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL thresh_alarm_early: got %b expected 0", alarm_pre);
    end
    tests_run++;
    if ({win_valid, win_count, alarm} !== {1'b1, 8'd4, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL thresh_report: got v=%b n=%0d a=%b expected v=1 n=4 a=1",
               win_valid, win_count, alarm);
    end
    ff2 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c < 15 && win_valid) early++;
    end
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("[TB] FAIL thresh_early_strobe: got %0d expected 0", early);
    end
    tests_run++;
    if ({win_valid, win_count, alarm, total_cnt} !== {1'b1, 8'd0, 1'b1, 8'd4}) begin
      tests_failed++;
      $display("[TB] FAIL thresh_sticky: got v=%b n=%0d a=%b t=%0d expected v=1 n=0 a=1 t=4",
               win_valid, win_count, alarm, total_cnt);
    end
  endtask

  // A level held high counts once.
  task automatic test_level();
    logic       wv15, wv31;
    logic [7:0] wc15, wc31;
    wv15 = 1'bx; wv31 = 1'bx; wc15 = 'x; wc31 = 'x;
    do_reset();
    en = 1'b1;
    step();
    ff2 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (c == 15) begin wv15 = win_valid; wc15 = win_count; end
      if (c == 31) begin wv31 = win_valid; wc31 = win_count; end
    end
    ff2 = 1'b0;
    step();
    tests_run++;
    if (total_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL level_total: got %0d expected 1", total_cnt);
    end
    tests_run++;
    if ({wv15, wc15, wv31, wc31} !== {1'b1, 8'd1, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL level_windows: got %b/%0d %b/%0d expected 1/1 1/0",
               wv15, wc15, wv31, wc31);
    end
    tests_run++;
    if (alarm !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL level_alarm: got %b expected 0", alarm);
    end
  endtask

  // Ten pulses. The CNT_W=3 instance saturates at 7 instead of wrapping.
  task automatic test_saturation();
    logic [2:0] wc3_15;
    logic [7:0] wc_15;
    wc3_15 = 'x;
    wc_15  = 'x;
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      ff2 = ((c % 2) == 0);
      step();
      if (c == 15) begin wc3_15 = win_count3; wc_15 = win_count; end
    end
    ff2 = 1'b0;
    step();
    tests_run++;
    if (total_cnt3 !== 3'd7) begin
      tests_failed++;
      $display("[TB] FAIL sat_total_w3: got %0d expected 7", total_cnt3);
    end
    tests_run++;
    if (total_cnt !== 8'd10) begin
      tests_failed++;
      $display("[TB] FAIL sat_total_w8: got %0d expected 10", total_cnt);
    end
    tests_run++;
    if ({wc3_15, wc_15} !== {3'd7, 8'd8}) begin
      tests_failed++;
      $display("[TB] FAIL sat_window: got w3=%0d w8=%0d expected w3=7 w8=8", wc3_15, wc_15);
    end
    tests_run++;
    if (alarm3 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sat_alarm_w3: got %b expected 1", alarm3);
    end
  endtask

  // en drops at win_cnt=10. The partial window is dropped and a fresh one follows.
  task automatic test_abort();
    int early;
    early = 0;
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      ff2 = (c == 3);
      step();
      if (win_valid) early++;
    end
    en  = 1'b0;
    ff2 = 1'b0;
    step();
    tests_run++;
    if ({busy, win_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL abort_idle: got busy=%b v=%b expected busy=0 v=0", busy, win_valid);
    end
    ff2 = 1'b1;
    step();
    if (win_valid) early++;
    ff2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (win_valid) early++;
    end
    tests_run++;
    if (total_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL abort_total_held: got %0d expected 1", total_cnt);
    end
    en = 1'b1;
    step();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_reentry_busy: got %b expected 1", busy);
    end
    for (int c = 0; c < 16; c++) begin
      ff2 = (c == 0 || c == 6);
      step();
      if (c < 15 && win_valid) early++;
    end
    ff2 = 1'b0;
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_stray_strobe: got %0d expected 0", early);
    end
    tests_run++;
    if ({win_valid, win_count, total_cnt} !== {1'b1, 8'd2, 8'd3}) begin
      tests_failed++;
      $display("[TB] FAIL abort_fresh_window: got v=%b n=%0d t=%0d expected v=1 n=2 t=3",
               win_valid, win_count, total_cnt);
    end
  endtask

  // clr on a window end while the alarm is set.
  task automatic test_clear();
    int early;
    early = 0;
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 16; c++) begin
      ff2 = ((c % 2) == 0) && (c < 8);
      step();
    end
    tests_run++;
    if ({win_valid, win_count, alarm} !== {1'b1, 8'd4, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL clear_setup: got v=%b n=%0d a=%b expected v=1 n=4 a=1",
               win_valid, win_count, alarm);
    end
    for (int c = 0; c < 15; c++) begin
      ff2 = (c == 1 || c == 3 || c == 5);
      step();
    end
    ff2 = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    ff2 = 1'b0;
    tests_run++;
    if ({win_valid, alarm, total_cnt, win_count, busy} !== {1'b0, 1'b0, 8'd0, 8'd4, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL clear_effect: got v=%b a=%b t=%0d n=%0d busy=%b expected v=0 a=0 t=0 n=4 busy=1",
               win_valid, alarm, total_cnt, win_count, busy);
    end
    for (int c = 0; c < 16; c++) begin
      step();
      if (c < 15 && win_valid) early++;
    end
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("[TB] FAIL clear_early_strobe: got %0d expected 0", early);
    end
    tests_run++;
    if ({win_valid, win_count, alarm, total_cnt} !== {1'b1, 8'd0, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL clear_next_window: got v=%b n=%0d a=%b t=%0d expected v=1 n=0 a=0 t=0",
               win_valid, win_count, alarm, total_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    ff2 = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    test_reset();
    test_below_threshold();
    test_threshold();
    test_level();
    test_saturation();
    test_abort();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
